data_mem_resp: RTL

Data-memory responder for the single-cycle core's load/store port. It accepts the core's read/write enables, byte address and store data, and services them from a word-organised RAM with a programmable number of wait states. While an access is in flight it holds the core with a stall signal. It also drives the MemtoReg write-back mux that feeds the register bank's write data.

---
 rtl/data_mem_resp.sv | 112 +++++++++++
 1 files changed

// File: rtl/data_mem_resp.sv
// Data-memory responder for the core's load/store port: word RAM with a
// fixed number of wait states, a stall to hold the core, fault detection,
// and the MemtoReg write-back mux.
module data_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLOCK,
  input  logic        RST_n,
  input  logic        ena_rd,
  input  logic        ena_wr,
  input  logic [31:0] alu_out_ext,
  input  logic [31:0] dataram_wr,
  input  logic        MemtoReg_sig,
  output logic [31:0] datareg_wr,
  output logic        stall,
  output logic        mem_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            wr_q;
  logic [31:0]     rd_q;
  logic [31:0]     ram [DEPTH_WORDS];

  logic [AW-1:0]   idx_c;
  logic            req_c;
  logic            addr_bad_c;
  logic            fault_c;
  logic            idle_c;
  logic            accept_c;
  logic            fault_evt_c;
  logic            fault_wr_c;
  logic            access_c;

  // Request decode: alignment, range and conflicting-enable checks
  assign idx_c       = alu_out_ext[AW+1:2];
  assign req_c       = ena_rd | ena_wr;
  assign addr_bad_c  = (alu_out_ext[1:0] != 2'b00) | ((alu_out_ext >> (AW + 2)) != 32'd0);
  assign fault_c     = addr_bad_c | (ena_rd & ena_wr);
  assign idle_c      = (state_q == IDLE);
  assign accept_c    = idle_c & req_c & ~fault_c;
  assign fault_evt_c = idle_c & req_c & fault_c;
  assign fault_wr_c  = idle_c & ena_rd & ena_wr & ~addr_bad_c;
  assign access_c    = (state_q == BUSY) && (cnt_q == '0);

  // State register
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and combinational outputs
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    datareg_wr = MemtoReg_sig ? rd_q : alu_out_ext;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = BUSY;
          stall   = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, wait counter, load data and fault pulse
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      mem_err <= 1'b0;
    end else begin
      mem_err <= fault_evt_c;
      if (accept_c) begin
        cnt_q   <= CNT_INIT;
        idx_q   <= idx_c;
        wdata_q <= dataram_wr;
        wr_q    <= ena_wr;
      end else if ((state_q == BUSY) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (access_c && !wr_q) rd_q <= ram[idx_q];
      else if (fault_evt_c)  rd_q <= '0;
    end
  end

  // Storage: committed at the end of the wait, or directly for a legal conflicting request
  always_ff @(posedge CLOCK) begin
    if (access_c && wr_q) ram[idx_q] <= wdata_q;
    else if (fault_wr_c)  ram[idx_c] <= dataram_wr;
  end

endmodule
